// File: rtl/bk_pkg.sv
// Shared types and constants for the Brent-Kung adder operand sequencer.
package bk_pkg;

   // Default operand width of the attached adder netlist.
   localparam int BK_WIDTH = 12;

   // Width of the settle counter; holds settle windows of 1..15 cycles.
   localparam int BK_CNT_W = 4;

   // Sequencer control states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } bk_state_e;

   // Builds the adder's interleaved input bus: bit 2i carries A[i], bit 2i+1 carries B[i].
   function automatic logic [2*BK_WIDTH-1:0] bk_interleave(
      input logic [BK_WIDTH-1:0] a,
      input logic [BK_WIDTH-1:0] b
   );
      logic [2*BK_WIDTH-1:0] bus;
      bus = '0;
      for (int i = 0; i < BK_WIDTH; i++) begin
         bus[2*i]   = a[i];
         bus[2*i+1] = b[i];
      end
      return bus;
   endfunction

endpackage

// File: rtl/bk_add_sequencer_acc.sv
// Running accumulator with sticky overflow flag; a clear always beats a write-back.
module bk_add_sequencer_acc
   import bk_pkg::*;
#(
   parameter int WIDTH = BK_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             wr_i,
   input  logic [WIDTH-1:0] sum_i,
   input  logic             carry_i,
   output logic [WIDTH-1:0] acc_o,
   output logic             ovf_o
);

   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_d;
   logic             ovf_q;
   logic             ovf_d;

   // Next accumulator value: clear has priority, otherwise take the captured sum.
   always_comb begin
      acc_d = acc_q;
      ovf_d = ovf_q;
      if (clr_i) begin
         acc_d = '0;
         ovf_d = 1'b0;
      end else if (wr_i) begin
         acc_d = sum_i;
         ovf_d = ovf_q | carry_i;
      end
   end

   // Accumulator and overflow registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         ovf_q <= ovf_d;
      end
   end

   assign acc_o = acc_q;
   assign ovf_o = ovf_q;

endmodule

// File: rtl/bk_add_sequencer.sv
// Operand sequencer for the 12-bit Brent-Kung adder: registers the interleaved
// operand bus, holds it for a settle window, captures the result and hands it on.
module bk_add_sequencer
   import bk_pkg::*;
#(
   parameter int WIDTH         = BK_WIDTH,
   parameter int SETTLE_CYCLES = 1          // legal range 1..15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic               in_acc,
   input  logic               acc_clr,
   output logic [2*WIDTH-1:0] adder_in,
   input  logic [WIDTH:0]     adder_out,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [WIDTH-1:0]   res_sum,
   output logic               res_cout,
   output logic [WIDTH-1:0]   acc,
   output logic               acc_ovf
);

   localparam logic [BK_CNT_W-1:0] SETTLE_LOAD = BK_CNT_W'(SETTLE_CYCLES);
   localparam logic [BK_CNT_W-1:0] CNT_ONE     = BK_CNT_W'(1);

   bk_state_e            state_q;
   bk_state_e            state_d;
   logic [BK_CNT_W-1:0]  cnt_q;
   logic [BK_CNT_W-1:0]  cnt_d;
   logic                 acc_mode_q;
   logic                 acc_mode_d;
   logic [2*WIDTH-1:0]   adder_in_q;
   logic [2*WIDTH-1:0]   adder_in_d;
   logic [WIDTH-1:0]     res_sum_q;
   logic [WIDTH-1:0]     res_sum_d;
   logic                 res_cout_q;
   logic                 res_cout_d;
   logic                 res_valid_q;
   logic                 res_valid_d;

   logic                 accept;
   logic                 acc_wr;
   logic [WIDTH-1:0]     acc_val;
   logic [WIDTH-1:0]     op_a;
   logic [2*WIDTH-1:0]   ilv_bus;

   // Operand A comes from the accumulator in accumulate mode; a simultaneous clear reads as zero.
   always_comb begin
      op_a = in_a;
      if (in_acc) begin
         op_a = acc_clr ? '0 : acc_val;
      end
   end

   // Interleave A and B onto the adder bus bit by bit.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ilv
      assign ilv_bus[2*gi]   = op_a[gi];
      assign ilv_bus[2*gi+1] = in_b[gi];
   end

   // Handshake readiness depends only on state and reset.
   assign in_ready = (state_q == IDLE) & ~rst;
   assign accept   = in_valid & in_ready;

   // Next-state logic: accept in IDLE, count down in SETTLE, wait for the consumer in HOLD.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_mode_d  = acc_mode_q;
      adder_in_d  = adder_in_q;
      res_sum_d   = res_sum_q;
      res_cout_d  = res_cout_q;
      res_valid_d = res_valid_q;
      acc_wr      = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               adder_in_d = ilv_bus;
               acc_mode_d = in_acc;
               cnt_d      = SETTLE_LOAD;
               state_d    = SETTLE;
            end
         end
         SETTLE: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               res_sum_d   = adder_out[WIDTH-1:0];
               res_cout_d  = adder_out[WIDTH];
               res_valid_d = 1'b1;
               acc_wr      = acc_mode_q;
               state_d     = HOLD;
            end
         end
         HOLD: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            res_valid_d = 1'b0;
         end
      endcase
   end

   // Control and datapath registers; reset drops any in-flight operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         acc_mode_q  <= 1'b0;
         adder_in_q  <= '0;
         res_sum_q   <= '0;
         res_cout_q  <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_mode_q  <= acc_mode_d;
         adder_in_q  <= adder_in_d;
         res_sum_q   <= res_sum_d;
         res_cout_q  <= res_cout_d;
         res_valid_q <= res_valid_d;
      end
   end

   bk_add_sequencer_acc #(
      .WIDTH (WIDTH)
   ) u_acc (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (acc_clr),
      .wr_i    (acc_wr),
      .sum_i   (adder_out[WIDTH-1:0]),
      .carry_i (adder_out[WIDTH]),
      .acc_o   (acc_val),
      .ovf_o   (acc_ovf)
   );

   assign adder_in  = adder_in_q;
   assign res_sum   = res_sum_q;
   assign res_cout  = res_cout_q;
   assign res_valid = res_valid_q;
   assign acc       = acc_val;

endmodule

// File: tb/tb_bk_add_sequencer.sv
// Bench for bk_add_sequencer: one instance with a single-cycle settle window and
// one with a three-cycle window, each paired with a behavioural a+b adder.
module tb_bk_add_sequencer;

   localparam int W = 12;

   logic          clk;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          in_acc;

   logic          rst1, in_valid1, acc_clr1, res_ready1;
   logic          in_ready1, res_valid1, res_cout1, acc_ovf1;
   logic [2*W-1:0] adder_in1;
   logic [W:0]    adder_out1;
   logic [W-1:0]  res_sum1, acc1;

   logic          rst3, in_valid3, acc_clr3, res_ready3;
   logic          in_ready3, res_valid3, res_cout3, acc_ovf3;
   logic [2*W-1:0] adder_in3;
   logic [W:0]    adder_out3;
   logic [W-1:0]  res_sum3, acc3;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   logic [W:0] sb[$];

   // Behavioural adder: de-interleave the bus and add.
   function automatic logic [W:0] mdl_add(input logic [2*W-1:0] bus);
      logic [W-1:0] a, b;
      for (int i = 0; i < W; i++) begin
         a[i] = bus[2*i];
         b[i] = bus[2*i+1];
      end
      return {1'b0, a} + {1'b0, b};
   endfunction

   function automatic logic [2*W-1:0] mdl_ilv(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] bus;
      for (int i = 0; i < W; i++) begin
         bus[2*i]   = a[i];
         bus[2*i+1] = b[i];
      end
      return bus;
   endfunction

   assign adder_out1 = mdl_add(adder_in1);
   assign adder_out3 = mdl_add(adder_in3);

   bk_add_sequencer #(.WIDTH(W), .SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
      .in_a(in_a), .in_b(in_b), .in_acc(in_acc), .acc_clr(acc_clr1),
      .adder_in(adder_in1), .adder_out(adder_out1), .res_valid(res_valid1),
      .res_ready(res_ready1), .res_sum(res_sum1), .res_cout(res_cout1),
      .acc(acc1), .acc_ovf(acc_ovf1)
   );

   bk_add_sequencer #(.WIDTH(W), .SETTLE_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst3), .in_valid(in_valid3), .in_ready(in_ready3),
      .in_a(in_a), .in_b(in_b), .in_acc(in_acc), .acc_clr(acc_clr3),
      .adder_in(adder_in3), .adder_out(adder_out3), .res_valid(res_valid3),
      .res_ready(res_ready3), .res_sum(res_sum3), .res_cout(res_cout3),
      .acc(acc3), .acc_ovf(acc_ovf3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer an operand pair to dut1 until it is taken; returns just after the acceptance edge.
   task automatic accept1(input logic [W-1:0] a, input logic [W-1:0] b, input logic m, output bit ok);
      logic rdy;
      in_a = a; in_b = b; in_acc = m; in_valid1 = 1'b1; ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         rdy = in_ready1;
         step();
         if (rdy) begin ok = 1'b1; break; end
      end
      in_valid1 = 1'b0;
   endtask

   task automatic wait_res1(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (res_valid1) begin ok = 1'b1; break; end
         step();
      end
   endtask

   task automatic test_reset();
      step(); step();
      checks++;
      if ({adder_in1, res_sum1, res_cout1, res_valid1, acc1, acc_ovf1, in_ready1} !== '0) begin
         failures++;
         $display("FAIL reset1 got adder_in=%h sum=%h cout=%b v=%b acc=%h ovf=%b rdy=%b required all 0",
                  adder_in1, res_sum1, res_cout1, res_valid1, acc1, acc_ovf1, in_ready1);
      end
      checks++;
      if ({adder_in3, res_sum3, res_cout3, res_valid3, acc3, acc_ovf3, in_ready3} !== '0) begin
         failures++;
         $display("FAIL reset3 got adder_in=%h sum=%h v=%b acc=%h rdy=%b required all 0",
                  adder_in3, res_sum3, res_valid3, acc3, in_ready3);
      end
      rst1 = 1'b0; rst3 = 1'b0;
      #1;
      checks++;
      if (in_ready1 !== 1'b1 || in_ready3 !== 1'b1) begin
         failures++;
         $display("FAIL ready_after_reset got %b/%b required 1/1", in_ready1, in_ready3);
      end
      $display("reset: done");
   endtask

   task automatic test_wrap();
      bit ok;
      logic [W:0] exp;
      res_ready1 = 1'b1;
      sb.push_back({1'b0, 12'hFFF} + {1'b0, 12'h001});
      accept1(12'hFFF, 12'h001, 1'b0, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL wrap_accept timeout"); end
      checks++;
      if (adder_in1 !== 24'h555557) begin
         failures++; $display("FAIL wrap_adder_in got=%h required=555557", adder_in1);
      end
      checks++;
      if (res_valid1 !== 1'b0) begin failures++; $display("FAIL wrap_early_valid got=%b required=0", res_valid1); end
      step();
      checks++;
      if (res_valid1 !== 1'b1) begin
         failures++; $display("FAIL wrap_latency res_valid got=%b required=1", res_valid1);
      end else begin
         exp = sb.pop_front();
         checks++;
         if ({res_cout1, res_sum1} !== exp) begin
            failures++; $display("FAIL wrap_result got=%h required=%h", {res_cout1, res_sum1}, exp);
         end
      end
      $display("wrap: a=fff b=001 -> sum=%h cout=%b", res_sum1, res_cout1);
      step();
      checks++;
      if (res_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
         failures++; $display("FAIL wrap_release got v=%b rdy=%b required 0/1", res_valid1, in_ready1);
      end
   endtask

   task automatic test_accumulate();
      bit ok;
      logic [W:0] exp;
      logic [W-1:0] macc;
      logic movf;
      res_ready1 = 1'b1;
      acc_clr1 = 1'b1; step(); acc_clr1 = 1'b0;
      macc = '0; movf = 1'b0;
      for (int k = 0; k < 2; k++) begin
         exp = {1'b0, macc} + {1'b0, 12'h800};
         sb.push_back(exp);
         macc = exp[W-1:0]; movf = movf | exp[W];
         accept1(12'hABC, 12'h800, 1'b1, ok);
         wait_res1(ok);
         checks++;
         if (!ok) begin
            failures++; $display("FAIL acc_op%0d timeout", k);
         end else begin
            exp = sb.pop_front();
            checks++;
            if ({res_cout1, res_sum1} !== exp) begin
               failures++; $display("FAIL acc_op%0d_result got=%h required=%h", k, {res_cout1, res_sum1}, exp);
            end
            checks++;
            if (acc1 !== macc || acc_ovf1 !== movf) begin
               failures++; $display("FAIL acc_op%0d_state got acc=%h ovf=%b required acc=%h ovf=%b",
                                    k, acc1, acc_ovf1, macc, movf);
            end
         end
         $display("accumulate: op%0d acc=%h ovf=%b cout=%b", k, acc1, acc_ovf1, res_cout1);
         step();
      end
      acc_clr1 = 1'b1; step(); acc_clr1 = 1'b0;
      checks++;
      if (acc1 !== '0 || acc_ovf1 !== 1'b0) begin
         failures++; $display("FAIL acc_clear got acc=%h ovf=%b required 000/0", acc1, acc_ovf1);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      logic [W:0] exp;
      logic [2*W-1:0] held;
      res_ready1 = 1'b0;
      exp = {1'b0, 12'h123} + {1'b0, 12'h456};
      sb.push_back(exp);
      accept1(12'h123, 12'h456, 1'b0, ok);
      held = mdl_ilv(12'h123, 12'h456);
      wait_res1(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL bp_timeout"); end
      exp = sb.pop_front();
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (res_valid1 !== 1'b1 || {res_cout1, res_sum1} !== exp || in_ready1 !== 1'b0 || adder_in1 !== held) begin
            failures++;
            $display("FAIL bp_hold%0d got v=%b res=%h rdy=%b bus=%h required 1/%h/0/%h",
                     k, res_valid1, {res_cout1, res_sum1}, in_ready1, adder_in1, exp, held);
         end
         step();
      end
      res_ready1 = 1'b1;
      step();
      checks++;
      if (res_valid1 !== 1'b0 || in_ready1 !== 1'b1 || res_sum1 !== exp[W-1:0]) begin
         failures++; $display("FAIL bp_release got v=%b rdy=%b sum=%h required 0/1/%h",
                              res_valid1, in_ready1, res_sum1, exp[W-1:0]);
      end
      $display("backpressure: 123+456 held 5 cycles sum=%h", res_sum1);
   endtask

   task automatic test_clear_collision();
      bit ok;
      logic [W:0] exp;
      res_ready1 = 1'b1;
      acc_clr1 = 1'b1; step(); acc_clr1 = 1'b0;
      sb.push_back({1'b0, 12'h100});
      accept1(12'h000, 12'h100, 1'b1, ok);
      wait_res1(ok);
      exp = sb.pop_front();
      checks++;
      if (!ok || acc1 !== exp[W-1:0]) begin
         failures++; $display("FAIL coll_preload got acc=%h required=%h", acc1, exp[W-1:0]);
      end
      step();
      sb.push_back({1'b0, 12'h100} + {1'b0, 12'h001});
      accept1(12'h000, 12'h001, 1'b1, ok);
      acc_clr1 = 1'b1;
      step();
      acc_clr1 = 1'b0;
      checks++;
      if (res_valid1 !== 1'b1) begin
         failures++; $display("FAIL coll_valid got=%b required=1", res_valid1);
      end else begin
         exp = sb.pop_front();
         checks++;
         if ({res_cout1, res_sum1} !== exp) begin
            failures++; $display("FAIL coll_result got=%h required=%h", {res_cout1, res_sum1}, exp);
         end
      end
      checks++;
      if (acc1 !== '0 || acc_ovf1 !== 1'b0) begin
         failures++; $display("FAIL coll_acc got acc=%h ovf=%b required 000/0", acc1, acc_ovf1);
      end
      $display("clear_collision: sum=%h acc=%h ovf=%b", res_sum1, acc1, acc_ovf1);
      step();
   endtask

   task automatic test_back_to_back();
      logic rdy, vld;
      logic [W:0] exp;
      int acc_cyc[$];
      res_ready1 = 1'b1; in_acc = 1'b0;
      in_a = W'($urandom); in_b = W'($urandom);
      for (int i = 0; i < 40; i++) begin
         in_valid1 = (i < 30);
         rdy = in_ready1; vld = res_valid1;
         if (vld) begin
            checks++;
            if (sb.size() == 0) begin
               failures++; $display("FAIL b2b_unexpected got=%h required none", {res_cout1, res_sum1});
            end else begin
               exp = sb.pop_front();
               if ({res_cout1, res_sum1} !== exp) begin
                  failures++; $display("FAIL b2b_result got=%h required=%h", {res_cout1, res_sum1}, exp);
               end
               $display("b2b: result %h", {res_cout1, res_sum1});
            end
         end
         if (rdy && in_valid1) begin
            sb.push_back({1'b0, in_a} + {1'b0, in_b});
            acc_cyc.push_back(cyc);
         end
         step();
         if (rdy && in_valid1) begin
            in_a = W'($urandom); in_b = W'($urandom);
         end
      end
      in_valid1 = 1'b0;
      checks++;
      if (sb.size() != 0 || acc_cyc.size() < 8) begin
         failures++; $display("FAIL b2b_drain got left=%0d ops=%0d required 0/>=8", sb.size(), acc_cyc.size());
      end
      for (int k = 1; k < acc_cyc.size(); k++) begin
         checks++;
         if (acc_cyc[k] - acc_cyc[k-1] != 3) begin
            failures++; $display("FAIL b2b_spacing got=%0d required=3", acc_cyc[k] - acc_cyc[k-1]);
         end
      end
      sb.delete();
   endtask

   task automatic test_settle3();
      logic rdy;
      bit ok;
      logic [W:0] exp;
      res_ready3 = 1'b1;
      in_a = 12'h0AA; in_b = 12'h055; in_acc = 1'b0;
      in_valid3 = 1'b1;
      sb.push_back({1'b0, 12'h0AA} + {1'b0, 12'h055});
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         rdy = in_ready3; step();
         if (rdy) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok || adder_in3 !== mdl_ilv(12'h0AA, 12'h055)) begin
         failures++; $display("FAIL s3_accept got bus=%h required=%h", adder_in3, mdl_ilv(12'h0AA, 12'h055));
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (res_valid3 !== 1'b0 || in_ready3 !== 1'b0) begin
            failures++; $display("FAIL s3_settle%0d got v=%b rdy=%b required 0/0", k, res_valid3, in_ready3);
         end
         step();
      end
      checks++;
      if (res_valid3 !== 1'b1) begin
         failures++; $display("FAIL s3_latency got v=%b required=1", res_valid3);
      end else begin
         exp = sb.pop_front();
         checks++;
         if ({res_cout3, res_sum3} !== exp) begin
            failures++; $display("FAIL s3_result got=%h required=%h", {res_cout3, res_sum3}, exp);
         end
      end
      $display("settle3: 0aa+055 sum=%h", res_sum3);
      step();
      checks++;
      if (in_ready3 !== 1'b1 || res_valid3 !== 1'b0) begin
         failures++; $display("FAIL s3_idle got rdy=%b v=%b required 1/0", in_ready3, res_valid3);
      end
      sb.push_back({1'b0, 12'h0AA} + {1'b0, 12'h055});
      step();
      in_valid3 = 1'b0;
      checks++;
      if (in_ready3 !== 1'b0) begin
         failures++; $display("FAIL s3_reaccept got rdy=%b required 0", in_ready3);
      end
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (res_valid3) begin ok = 1'b1; break; end
         step();
      end
      checks++;
      if (!ok) begin
         failures++; $display("FAIL s3_second timeout");
      end else begin
         exp = sb.pop_front();
         if ({res_cout3, res_sum3} !== exp) begin
            failures++; $display("FAIL s3_second got=%h required=%h", {res_cout3, res_sum3}, exp);
         end
      end
      step();
   endtask

   task automatic test_reset_mid();
      logic rdy;
      in_a = 12'h123; in_b = 12'h456; in_acc = 1'b0;
      in_valid3 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         rdy = in_ready3; step();
         if (rdy) break;
      end
      in_valid3 = 1'b0;
      rst3 = 1'b1;
      step();
      checks++;
      if ({adder_in3, res_sum3, res_cout3, res_valid3, acc3, acc_ovf3, in_ready3} !== '0) begin
         failures++;
         $display("FAIL midrst_state got bus=%h sum=%h cout=%b v=%b acc=%h ovf=%b rdy=%b required all 0",
                  adder_in3, res_sum3, res_cout3, res_valid3, acc3, acc_ovf3, in_ready3);
      end
      rst3 = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         checks++;
         if (res_valid3 !== 1'b0 || acc3 !== '0) begin
            failures++; $display("FAIL midrst_quiet%0d got v=%b acc=%h required 0/000", k, res_valid3, acc3);
         end
      end
      $display("reset_mid: dropped op, rdy=%b", in_ready3);
   endtask

   initial begin
      rst1 = 1'b1; rst3 = 1'b1;
      in_valid1 = 1'b0; in_valid3 = 1'b0;
      acc_clr1 = 1'b0; acc_clr3 = 1'b0;
      res_ready1 = 1'b1; res_ready3 = 1'b1;
      in_a = '0; in_b = '0; in_acc = 1'b0;
      test_reset();
      test_wrap();
      test_accumulate();
      test_backpressure();
      test_clear_collision();
      test_back_to_back();
      test_settle3();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
